// File: rtl/alarm_pkg.sv
// alarm_pkg: state codes, parameter indices and default times for the alarm core
package alarm_pkg;
  typedef enum logic [2:0] {
    ARMED       = 3'd0,
    TRIGGERED   = 3'd1,
    SOUND_ALARM = 3'd2,
    DISARMED    = 3'd3,
    DOOR_OPEN   = 3'd4,
    WAIT_ARM    = 3'd5
  } state_t;
  typedef enum logic [1:0] {
    P_ARM       = 2'd0,
    P_DRIVER    = 2'd1,
    P_PASSENGER = 2'd2,
    P_ALARM     = 2'd3
  } param_t;
  localparam int DEF_T_ARM       = 6;
  localparam int DEF_T_DRIVER    = 8;
  localparam int DEF_T_PASSENGER = 15;
  localparam int DEF_T_ALARM     = 10;
endpackage

// File: rtl/alarm_timer.sv
// alarm_timer: 1 s tick prescaler plus loadable seconds countdown
module alarm_timer #(
  parameter int TW     = 4,
  parameter int CLK_HZ = 100_000_000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [TW-1:0] value,
  output logic [TW-1:0] counter,
  output logic          expired,
  output logic          tick
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  logic [PW-1:0] presc_q;
  logic [TW-1:0] cnt_q;
  logic          run_q;
  assign tick    = presc_q == PMAX;
  assign expired = run_q && cnt_q == '0;
  assign counter = cnt_q;
  // prescaler realigns on every load so the first second is a full second
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      presc_q <= (start || tick) ? '0 : presc_q + 1'b1;
      cnt_q   <= start ? value : stop ? '0 : (tick && run_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      run_q   <= start | (run_q & ~stop);
    end
  end
endmodule

// File: rtl/alarm_core_multi.sv
// alarm_core_multi: multi-door car alarm FSM with reprogrammable timings
module alarm_core_multi
  import alarm_pkg::*;
#(
  parameter int N_DOORS = 4,
  parameter int TW      = 4,
  parameter int CLK_HZ  = 100_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] doors,
  input  logic               reprogram,
  input  logic [1:0]         param_sel,
  input  logic [TW-1:0]      param_value,
  output logic [2:0]         estado,
  output logic [TW-1:0]      counter,
  output logic [N_DOORS-1:0] trig_mask,
  output logic               siren_en,
  output logic               status
);
  state_t             state_q, state_d;
  logic [N_DOORS-1:0] mask_q, mask_d;
  logic [TW-1:0]      t_q [4];
  logic [TW-1:0]      load_val;
  logic               rep_q, rep_edge, any_open;
  logic               start, stop, expired, tick;
  logic               siren_q, siren_d, status_q, status_d;
  assign rep_edge  = reprogram & ~rep_q;
  assign any_open  = |doors;
  assign estado    = state_q;
  assign trig_mask = mask_q;
  assign siren_en  = siren_q;
  assign status    = status_q;
  alarm_timer #(.TW(TW), .CLK_HZ(CLK_HZ)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .value   (load_val),
    .counter (counter),
    .expired (expired),
    .tick    (tick)
  );
  // reprogram edge detector and time registers; a zero write is discarded
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q            <= 1'b0;
      t_q[P_ARM]       <= TW'(DEF_T_ARM);
      t_q[P_DRIVER]    <= TW'(DEF_T_DRIVER);
      t_q[P_PASSENGER] <= TW'(DEF_T_PASSENGER);
      t_q[P_ALARM]     <= TW'(DEF_T_ALARM);
    end else begin
      rep_q <= reprogram;
      if (rep_edge && param_value != '0) t_q[param_sel] <= param_value;
    end
  end
  // state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARMED;
      mask_q   <= '0;
      siren_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      siren_q  <= siren_d;
      status_q <= status_d;
    end
  end
  // next state, timer control and intrusion mask; reprogram overrides everything
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    start    = 1'b0;
    stop     = 1'b0;
    load_val = t_q[P_ALARM];
    case (state_q)
      ARMED: if (any_open) begin
        state_d  = TRIGGERED;
        start    = 1'b1;
        load_val = doors[0] ? t_q[P_DRIVER] : t_q[P_PASSENGER];
        mask_d   = doors;
      end
      TRIGGERED: begin
        mask_d = mask_q | doors;
        if (ignition) begin
          state_d = DISARMED;
          stop    = 1'b1;
        end else if (expired) begin
          state_d = SOUND_ALARM;
          start   = 1'b1;
        end
      end
      SOUND_ALARM: if (ignition) begin
        state_d = DISARMED;
        stop    = 1'b1;
      end else if (expired && any_open) begin
        start = 1'b1;
      end else if (expired) begin
        state_d = ARMED;
        stop    = 1'b1;
        mask_d  = '0;
      end
      DISARMED: if (!ignition && doors[0]) state_d = DOOR_OPEN;
      DOOR_OPEN: if (ignition) begin
        state_d = DISARMED;
      end else if (!any_open) begin
        state_d  = WAIT_ARM;
        start    = 1'b1;
        load_val = t_q[P_ARM];
      end
      WAIT_ARM: if (ignition) begin
        state_d = DISARMED;
        stop    = 1'b1;
      end else if (any_open) begin
        state_d = DOOR_OPEN;
        stop    = 1'b1;
      end else if (expired) begin
        state_d = ARMED;
        stop    = 1'b1;
        mask_d  = '0;
      end
      default: begin
        state_d = ARMED;
        stop    = 1'b1;
        mask_d  = '0;
      end
    endcase
    if (rep_edge) begin
      state_d = ARMED;
      start   = 1'b0;
      stop    = 1'b1;
      mask_d  = '0;
    end
  end
  // siren and status LED follow the state being entered
  always_comb begin
    siren_d  = state_d == SOUND_ALARM;
    status_d = (state_d == TRIGGERED || state_d == SOUND_ALARM) ? 1'b1 :
               (state_d == ARMED && state_q == ARMED) ? status_q ^ tick : 1'b0;
  end
endmodule

// File: tb/tb_alarm_core_multi.sv
// tb_alarm_core_multi: scoreboard-driven scenario checks of the alarm core
module tb_alarm_core_multi;
  typedef struct packed {
    logic [2:0] st;
    logic [3:0] cnt;
    logic [3:0] mask;
    logic       siren;
  } snap_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ignition = 1'b0;
  logic [3:0] doors = '0;
  logic       reprogram = 1'b0;
  logic [1:0] param_sel = '0;
  logic [3:0] param_value = '0;
  logic [2:0] estado;
  logic [3:0] counter;
  logic [3:0] trig_mask;
  logic       siren_en;
  logic       status;
  int         n_assert = 0;
  int         n_fail = 0;
  snap_t      exp_q[$];
  snap_t      e, o;
  alarm_core_multi #(.N_DOORS(4), .TW(4), .CLK_HZ(10)) dut (
    .clock       (clock),
    .reset       (reset),
    .ignition    (ignition),
    .doors       (doors),
    .reprogram   (reprogram),
    .param_sel   (param_sel),
    .param_value (param_value),
    .estado      (estado),
    .counter     (counter),
    .trig_mask   (trig_mask),
    .siren_en    (siren_en),
    .status      (status)
  );
  always #5 clock = ~clock;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  function automatic snap_t S(input int st, input int cnt, input logic [3:0] m, input logic sr);
    return '{st: 3'(st), cnt: 4'(cnt), mask: m, siren: sr};
  endfunction
  function automatic snap_t obs();
    return '{st: estado, cnt: counter, mask: trig_mask, siren: siren_en};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; ignition = 1'b0; doors = '0; reprogram = 1'b0; param_sel = '0; param_value = '0;
    step(2);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    doors = 4'b0100;
    step(5);
    reset = 1'b1; doors = '0;
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    reset = 1'b0;
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL reset_mid_count: got %p expected %p", o, e); end
    n_assert++;
    if (status !== 1'b0) begin n_fail++; $display("FAIL reset_status: got %b expected 0", status); end
    step(9);
    n_assert++;
    if (status !== 1'b0) begin n_fail++; $display("FAIL status_before_tick: got %b expected 0", status); end
    step(1);
    n_assert++;
    if (status !== 1'b1) begin n_fail++; $display("FAIL status_first_tick: got %b expected 1", status); end
    step(10);
    n_assert++;
    if (status !== 1'b0) begin n_fail++; $display("FAIL status_second_tick: got %b expected 0", status); end
  endtask
  task automatic test_passenger();
    do_reset();
    doors = 4'b0100;
    exp_q.push_back(S(1, 15, 4'b0100, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL pass_trigger: got %p expected %p", o, e); end
    n_assert++;
    if (status !== 1'b1) begin n_fail++; $display("FAIL pass_status: got %b expected 1", status); end
    exp_q.push_back(S(1, 14, 4'b0100, 1'b0));
    step(10);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL pass_first_tick: got %p expected %p", o, e); end
    exp_q.push_back(S(2, 10, 4'b0100, 1'b1));
    step(141);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL pass_sound: got %p expected %p", o, e); end
  endtask
  task automatic test_driver();
    do_reset();
    doors = 4'b0011;
    exp_q.push_back(S(1, 8, 4'b0011, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL drv_trigger: got %p expected %p", o, e); end
    exp_q.push_back(S(1, 5, 4'b0011, 1'b0));
    step(30);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL drv_three_ticks: got %p expected %p", o, e); end
    doors = 4'b1011;
    exp_q.push_back(S(1, 5, 4'b1011, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL drv_mask_join: got %p expected %p", o, e); end
    ignition = 1'b1;
    exp_q.push_back(S(3, 0, 4'b1011, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL drv_disarm: got %p expected %p", o, e); end
    n_assert++;
    if (status !== 1'b0) begin n_fail++; $display("FAIL drv_status: got %b expected 0", status); end
  endtask
  task automatic test_reprogram();
    do_reset();
    doors = 4'b0100;
    exp_q.push_back(S(1, 15, 4'b0100, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_trigger: got %p expected %p", o, e); end
    doors = '0; param_sel = 2'd1; param_value = 4'd3; reprogram = 1'b1;
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_force_armed: got %p expected %p", o, e); end
    doors = 4'b0001;
    exp_q.push_back(S(1, 3, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_new_driver: got %p expected %p", o, e); end
    reprogram = 1'b0; doors = '0;
    exp_q.push_back(S(1, 3, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_level_no_force: got %p expected %p", o, e); end
    param_value = 4'd0; reprogram = 1'b1;
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_zero_force: got %p expected %p", o, e); end
    reprogram = 1'b0; doors = 4'b0001;
    exp_q.push_back(S(1, 3, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL rp_zero_ignored: got %p expected %p", o, e); end
  endtask
  task automatic test_ign_expiry();
    do_reset();
    param_sel = 2'd2; param_value = 4'd1; reprogram = 1'b1;
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL ie_program: got %p expected %p", o, e); end
    reprogram = 1'b0; doors = 4'b0100;
    exp_q.push_back(S(1, 1, 4'b0100, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL ie_trigger: got %p expected %p", o, e); end
    exp_q.push_back(S(1, 0, 4'b0100, 1'b0));
    step(10);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL ie_reach_zero: got %p expected %p", o, e); end
    ignition = 1'b1;
    exp_q.push_back(S(3, 0, 4'b0100, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL ie_ignition_wins: got %p expected %p", o, e); end
  endtask
  task automatic test_sound_reload();
    do_reset();
    doors = 4'b0100;
    exp_q.push_back(S(1, 15, 4'b0100, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_trigger: got %p expected %p", o, e); end
    exp_q.push_back(S(2, 10, 4'b0100, 1'b1));
    step(151);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_sound: got %p expected %p", o, e); end
    exp_q.push_back(S(2, 0, 4'b0100, 1'b1));
    step(100);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_zero: got %p expected %p", o, e); end
    exp_q.push_back(S(2, 10, 4'b0100, 1'b1));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_reload: got %p expected %p", o, e); end
    doors = '0;
    exp_q.push_back(S(2, 0, 4'b0100, 1'b1));
    step(100);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_zero2: got %p expected %p", o, e); end
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL sr_rearm: got %p expected %p", o, e); end
  endtask
  task automatic test_door_cycle();
    do_reset();
    doors = 4'b0001;
    exp_q.push_back(S(1, 8, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_trigger: got %p expected %p", o, e); end
    ignition = 1'b1;
    exp_q.push_back(S(3, 0, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_disarm: got %p expected %p", o, e); end
    ignition = 1'b0;
    exp_q.push_back(S(4, 0, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_door_open: got %p expected %p", o, e); end
    doors = '0;
    exp_q.push_back(S(5, 6, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_wait_arm: got %p expected %p", o, e); end
    exp_q.push_back(S(5, 4, 4'b0001, 1'b0));
    step(20);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_two_ticks: got %p expected %p", o, e); end
    doors = 4'b0001;
    exp_q.push_back(S(4, 0, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_reopen: got %p expected %p", o, e); end
    doors = '0;
    exp_q.push_back(S(5, 6, 4'b0001, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_wait_again: got %p expected %p", o, e); end
    exp_q.push_back(S(5, 0, 4'b0001, 1'b0));
    step(60);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_zero: got %p expected %p", o, e); end
    exp_q.push_back(S(0, 0, 4'b0000, 1'b0));
    step(1);
    o = obs(); e = exp_q.pop_front(); n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL dc_armed: got %p expected %p", o, e); end
  endtask
  initial begin
    test_reset();
    test_passenger();
    test_driver();
    test_reprogram();
    test_ign_expiry();
    test_sound_reload();
    test_door_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_core_multi.md
ALARM_CORE_MULTI -- requirements
Module: alarm_core_multi

Interface
REQ-001 SHALL have parameter N_DOORS, default 4, number of door inputs (range 2..8); bit 0 is the driver door.
REQ-002 SHALL have parameter TW, default 4, width of every time parameter and of the countdown (minimum 4).
REQ-003 SHALL have parameter CLK_HZ, default 100_000_000, clock cycles per 1 s tick.
REQ-004 SHALL have port clock  in  1  system clock; one clock domain only.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ignition  in  1  debounced ignition level.
REQ-007 SHALL have port doors  in  N_DOORS  debounced door levels, 1 = open.
REQ-008 SHALL have port reprogram  in  1  debounced level; rising edge commits a parameter write.
REQ-009 SHALL have port param_sel  in  2  parameter index: 0 T_ARM, 1 T_DRIVER, 2 T_PASSENGER, 3 T_ALARM.
REQ-010 SHALL have port param_value  in  TW  value in seconds written on a reprogram edge.
REQ-011 SHALL have port estado  out  3  current FSM state code.
REQ-012 SHALL have port counter  out  TW  remaining seconds of the running timer; 0 when idle.
REQ-013 SHALL have port trig_mask  out  N_DOORS  sticky record of the doors that caused or joined an intrusion.
REQ-014 SHALL have ports siren_en  out  1  siren enable; status  out  1  status LED.

Function
REQ-015 SHALL encode states ARMED=0, TRIGGERED=1, SOUND_ALARM=2, DISARMED=3, DOOR_OPEN=4, WAIT_ARM=5.
REQ-016 SHALL hold four TW-bit time registers with defaults T_ARM=6, T_DRIVER=8, T_PASSENGER=15, T_ALARM=10.
REQ-017 SHALL detect the reprogram rising edge internally and, in the following cycle, write param_value to the register named by param_sel; a value of 0 SHALL be ignored (register unchanged).
REQ-018 SHALL, on a reprogram edge, also force ARMED, stop the timer and clear trig_mask; this SHALL take priority over every other transition.
REQ-019 SHALL generate a one-cycle tick every CLK_HZ cycles; the prescaler SHALL restart from 0 whenever the timer is loaded.
REQ-020 SHALL load counter with the selected time register on a timer start and decrement it by 1 on each tick while it is non-zero; expiry SHALL be seen when counter is 0 while running, and the FSM SHALL act in the cycle after the tick that reached 0.
REQ-021 In ARMED: any door open -> TRIGGERED; load T_DRIVER if doors[0]=1, else T_PASSENGER (driver wins on simultaneous openings); trig_mask <= doors; ignition ignored.
REQ-022 In TRIGGERED: ignition=1 -> DISARMED (ignition wins over same-cycle expiry); expiry -> SOUND_ALARM with T_ALARM loaded; newly opened doors OR into trig_mask.
REQ-023 In SOUND_ALARM: ignition=1 -> DISARMED; on expiry with all doors closed -> ARMED; on expiry with any door open, reload T_ALARM and remain.
REQ-024 In DISARMED: ignition=0 and doors[0]=1 -> DOOR_OPEN.
REQ-025 In DOOR_OPEN: ignition=1 -> DISARMED; all doors closed -> WAIT_ARM with T_ARM loaded.
REQ-026 In WAIT_ARM: ignition=1 -> DISARMED; any door open -> DOOR_OPEN (timer stopped); expiry -> ARMED.
REQ-027 trig_mask SHALL be cleared on every entry to ARMED and otherwise held.
REQ-028 siren_en SHALL be 1 only in SOUND_ALARM; status SHALL toggle on each tick in ARMED, be 1 in TRIGGERED/SOUND_ALARM, 0 elsewhere.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Reset SHALL set estado=ARMED, counter=0, timer stopped, prescaler=0, trig_mask=0, siren_en=0, status=0, edge detector=0, time registers to defaults; reset mid-countdown SHALL abort the countdown.

Structure
REQ-031 State codes, parameter indices and default times SHALL live in shared package alarm_pkg.
REQ-032 Prescaler plus countdown SHALL be a sub-module alarm_timer (inputs start, value; outputs counter, expired, tick).

Verification
REQ-033 CLK_HZ=10, reset -> estado 0, counter 0, siren_en 0; status toggles every 10 cycles.
REQ-034 ARMED, doors=0100 -> estado 1, counter 15, trig_mask 0100; 15 ticks later -> estado 2, counter 10, siren_en 1.
REQ-035 ARMED, doors=0011 same cycle -> counter 8, trig_mask 0011; ignition after 3 ticks -> estado 3, siren_en 0.
REQ-036 param_sel=1, value=3, reprogram edge -> estado 0; driver door open -> counter 3; later write of 0 leaves T_DRIVER 3.
REQ-037 SOUND_ALARM with door held open at expiry -> counter reloads 10, estado 2; close door, next expiry -> estado 0, trig_mask 0.
REQ-038 DISARMED, ignition 0, door0 open -> estado 4; close -> estado 5, counter 6; reopen at 2 ticks -> estado 4; close, 6 ticks -> estado 0.
